match_arbiter: RTL and testbench

MATCH_ARBITER -- requirements
Module: match_arbiter

---
 rtl/hydra_pkg.sv | 34 +++
 rtl/rr_picker.sv | 37 +++
 rtl/match_arbiter.sv | 156 +++++++++++++++
 tb/tb_match_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hydra_pkg.sv
// ---------------------------------------------------------------------------
// hydra_pkg -- shared definitions for the match arbiter slice.
//
// Contents:
//   PORT_NUM    number of frontends competing for the shared match engine
//   PTR_W       width of a frontend index (round-robin pointer, grant)
//   DEST_W      width of a per-frontend destination port field
//   SRAM_IDX_W  width of the engine's SRAM result index
//   LEN_W       width of a per-frontend match length (half-words)
//   CNT_W       width of the WAIT timeout counter (MATCH_TIMEOUT_EN builds)
//   state_e     arbiter FSM encoding
//   port_onehot helper turning a frontend index into a one-hot vector
// ---------------------------------------------------------------------------
package hydra_pkg;

    localparam int PORT_NUM   = 4;
    localparam int PTR_W      = 2;
    localparam int DEST_W     = 2;
    localparam int SRAM_IDX_W = 5;
    localparam int LEN_W      = 8;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    function automatic logic [PORT_NUM-1:0] port_onehot(input logic [PTR_W-1:0] idx);
        return {{(PORT_NUM-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker -- combinational round-robin priority search.
//
// Returns the first set request bit found by scanning upward from ptr+1,
// wrapping modulo PORT_NUM, so the port at ptr (the last one served) is
// considered last.
//
// Ports:
//   req    in  PORT_NUM  request vector
//   ptr    in  PTR_W     last-served index
//   found  out 1         at least one request bit is set
//   idx    out PTR_W     winning index (0 when found is low)
// ---------------------------------------------------------------------------
module rr_picker
    import hydra_pkg::*;
(
    input  logic [PORT_NUM-1:0] req,
    input  logic [PTR_W-1:0]    ptr,
    output logic                found,
    output logic [PTR_W-1:0]    idx
);

    // NOTE: every output gets a default before the loop so no path through
    // the block leaves a value unassigned, which would infer a latch.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        // k == PORT_NUM wraps back onto ptr itself, which is tried last.
        for (int k = 1; k <= PORT_NUM; k++) begin
            if (!found && req[ptr + PTR_W'(k)]) begin
                found = 1'b1;
                idx   = ptr + PTR_W'(k);
            end
        end
    end

endmodule

// File: rtl/match_arbiter.sv
// ---------------------------------------------------------------------------
// match_arbiter -- round-robin arbiter sharing one match engine among four
// frontends. A frontend holds match_enable high for as long as it wants
// service; the arbiter grants one at a time, starts the engine, returns the
// engine's SRAM index with a one-cycle match_suc pulse, and waits for the
// frontend to release its request before arbitrating again.
//
// Build option:
//   MATCH_TIMEOUT_EN  when defined, WAIT gives up after TIMEOUT_CYC cycles
//                     without eng_done, pulses eng_abort and moves on.
//                     When undefined, WAIT waits forever and eng_abort is 0.
//
// Parameters:
//   TIMEOUT_CYC      cycles WAIT tolerates before abort (timeout build only)
//
// Ports:
//   clk              in  1   clock, rising edge
//   rst_n            in  1   asynchronous active-low reset
//   match_enable     in  4   per-frontend request level
//   match_dest_port  in  8   dest port of frontend i at [i*2 +: 2]
//   match_length     in  32  length of frontend i at [i*8 +: 8]
//   match_suc        out 4   one-cycle completion pulse to the granted frontend
//   match_sram       out 5   SRAM index for the latest match_suc, held
//   eng_req          out 1   one-cycle engine start pulse
//   eng_dest_port    out 2   dest port of the granted frontend
//   eng_length       out 8   length of the granted frontend
//   eng_done         in  1   engine result-valid pulse
//   eng_sram         in  5   engine result, valid with eng_done
//   eng_abort        out 1   one-cycle engine cancel pulse
// ---------------------------------------------------------------------------
module match_arbiter
    import hydra_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PORT_NUM-1:0]        match_enable,
    input  logic [PORT_NUM*DEST_W-1:0] match_dest_port,
    input  logic [PORT_NUM*LEN_W-1:0]  match_length,
    output logic [PORT_NUM-1:0]        match_suc,
    output logic [SRAM_IDX_W-1:0]      match_sram,
    output logic                       eng_req,
    output logic [DEST_W-1:0]          eng_dest_port,
    output logic [LEN_W-1:0]           eng_length,
    input  logic                       eng_done,
    input  logic [SRAM_IDX_W-1:0]      eng_sram,
    output logic                       eng_abort
);

    state_e           state, state_nxt;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant;
    logic             pick_found;
    logic [PTR_W-1:0] pick_idx;
    logic             grant_live;   // granted frontend still requesting
    logic             timeout_hit;  // WAIT gives up this cycle

    rr_picker u_picker (
        .req   (match_enable),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign grant_live = match_enable[grant];

`ifdef MATCH_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;

    // eng_done in the last allowed cycle still counts as a normal completion.
    assign timeout_hit = (state == WAIT) && !eng_done &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            eng_abort <= 1'b0;
        end else begin
            eng_abort <= timeout_hit;
            if (state == ISSUE) begin
                wait_cnt <= '0;  // cleared on the way into WAIT
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign eng_abort   = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (pick_found) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                // A result for a frontend that already let go is dropped.
                if (eng_done)         state_nxt = grant_live ? HOLD : IDLE;
                else if (timeout_hit) state_nxt = IDLE;
            end
            HOLD:  if (!grant_live) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign eng_req = (state == ISSUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= PTR_W'(PORT_NUM - 1);  // first search starts at port 0
            grant         <= '0;
            eng_dest_port <= '0;
            eng_length    <= '0;
            match_suc     <= '0;
            match_sram    <= '0;
        end else begin
            match_suc <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant         <= pick_idx;
                        eng_dest_port <= match_dest_port[pick_idx*DEST_W +: DEST_W];
                        eng_length    <= match_length[pick_idx*LEN_W +: LEN_W];
                    end
                end
                WAIT: begin
                    if (eng_done && grant_live) begin
                        match_sram <= eng_sram;
                        match_suc  <= port_onehot(grant);
                    end else if (timeout_hit) begin
                        rr_ptr <= grant;
                    end
                end
                HOLD: begin
                    // Advancing the pointer only on release keeps a
                    // still-requesting frontend from being granted twice.
                    if (!grant_live) rr_ptr <= grant;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_match_arbiter.sv
// ---------------------------------------------------------------------------
// tb_match_arbiter -- directed bench for match_arbiter with a transaction
// model that predicts every output each cycle, plus literal expectations for
// the key scenarios. The timeout scenarios run only when MATCH_TIMEOUT_EN is
// defined (bench and DUT built with the same macro set).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_match_arbiter;

    localparam int TO = 8;
    localparam logic [1:0] DEST [4] = '{2'd2, 2'd0, 2'd3, 2'd1};
    localparam logic [7:0] LEN  [4] = '{8'd40, 8'd11, 8'd12, 8'd13};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  match_enable = 4'b0000;
    logic [7:0]  match_dest_port;
    logic [31:0] match_length;
    logic [3:0]  match_suc;
    logic [4:0]  match_sram;
    logic        eng_req;
    logic [1:0]  eng_dest_port;
    logic [7:0]  eng_length;
    logic        eng_done = 1'b0;
    logic [4:0]  eng_sram = 5'd0;
    logic        eng_abort;

    int checks = 0;
    int errors = 0;

    assign match_dest_port = {DEST[3], DEST[2], DEST[1], DEST[0]};
    assign match_length    = {LEN[3], LEN[2], LEN[1], LEN[0]};

    always #5 clk = ~clk;

    match_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .match_enable    (match_enable),
        .match_dest_port (match_dest_port),
        .match_length    (match_length),
        .match_suc       (match_suc),
        .match_sram      (match_sram),
        .eng_req         (eng_req),
        .eng_dest_port   (eng_dest_port),
        .eng_length      (eng_length),
        .eng_done        (eng_done),
        .eng_sram        (eng_sram),
        .eng_abort       (eng_abort)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    // owner: frontend holding the engine (-1 none); last: last frontend
    // released; fresh: the start pulse is due this cycle; waited: cycles
    // spent waiting on the engine; served: result already returned.
    int         m_owner = -1;
    int         m_last = 3;
    int         m_waited = 0;
    bit         m_served = 1'b0;
    logic       m_req = 1'b0;
    logic [1:0] m_dest = '0;
    logic [7:0] m_len = '0;
    logic [3:0] m_suc = '0;
    logic [4:0] m_sram = '0;
    logic       m_abort = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1; m_last <= 3; m_waited <= 0; m_served <= 1'b0;
            m_req <= 1'b0; m_dest <= '0; m_len <= '0; m_suc <= '0;
            m_sram <= '0; m_abort <= 1'b0;
        end else begin : step
            automatic int         o = m_owner;
            automatic int         l = m_last;
            automatic int         w = m_waited;
            automatic bit         sv = m_served;
            automatic logic       rq = 1'b0;
            automatic logic [1:0] d = m_dest;
            automatic logic [7:0] ln = m_len;
            automatic logic [3:0] sc = '0;
            automatic logic [4:0] sr = m_sram;
            automatic logic       ab = 1'b0;
            if (o < 0) begin
                for (int k = 1; k <= 4; k++) begin
                    if (o < 0 && match_enable[(l + k) % 4]) begin
                        o = (l + k) % 4;
                        d = DEST[o]; ln = LEN[o];
                        rq = 1'b1; sv = 1'b0;
                    end
                end
            end else if (m_req) begin
                w = 0;
            end else if (!sv) begin
                if (eng_done) begin
                    if (match_enable[o]) begin
                        sc = 4'b0001 << o; sr = eng_sram; sv = 1'b1;
                    end else begin
                        o = -1;
                    end
                end
`ifdef MATCH_TIMEOUT_EN
                else if (w == TO - 1) begin
                    ab = 1'b1; l = o; o = -1;
                end
`endif
                else begin
                    w = w + 1;
                end
            end else if (!match_enable[o]) begin
                l = o; o = -1;
            end
            m_owner <= o; m_last <= l; m_waited <= w; m_served <= sv;
            m_req <= rq; m_dest <= d; m_len <= ln; m_suc <= sc;
            m_sram <= sr; m_abort <= ab;
        end
    end

    // Every cycle, away from the active edge.
    always @(negedge clk) begin
        check("model eng_req", eng_req, m_req);
        check("model eng_dest_port", eng_dest_port, m_dest);
        check("model eng_length", eng_length, m_len);
        check("model match_suc", match_suc, m_suc);
        check("model match_sram", match_sram, m_sram);
        check("model eng_abort", eng_abort, m_abort);
        check("match_suc at most one hot", ($countones(match_suc) <= 1), 1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_req(input string tag);
        bit got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = (eng_req === 1'b1);
        end
        check({tag, " eng_req seen"}, got, 1);
    endtask

    // Drive eng_done for the current cycle; returns at the next negedge,
    // where any resulting match_suc is visible.
    task automatic pulse_done(input logic [4:0] s);
        eng_done = 1'b1; eng_sram = s;
        @(negedge clk);
        eng_done = 1'b0; eng_sram = 5'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("reset match_suc", match_suc, 0);
        check("reset match_sram", match_sram, 0);
        check("reset eng_req", eng_req, 0);
        check("reset eng_dest_port", eng_dest_port, 0);
        check("reset eng_length", eng_length, 0);
        check("reset eng_abort", eng_abort, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frontend, result three cycles after the start pulse.
        match_enable = 4'b0001;
        wait_req("t1");
        check("t1 eng_dest_port", eng_dest_port, 2);
        check("t1 eng_length", eng_length, 40);
        @(negedge clk);
        check("t1 eng_req single cycle", eng_req, 0);
        repeat (2) @(negedge clk);
        pulse_done(5'd17);
        check("t1 match_suc", match_suc, 4'b0001);
        check("t1 match_sram", match_sram, 17);
        @(negedge clk);
        check("t1 match_suc one cycle", match_suc, 0);
        check("t1 match_sram held", match_sram, 17);
        match_enable = 4'b0000;
        repeat (2) @(negedge clk);

        // All four requesting right after reset: grants 0,1,2,3.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        match_enable = 4'b1111;
        for (int p = 0; p < 4; p++) begin
            wait_req($sformatf("t2 port%0d", p));
            check($sformatf("t2 port%0d eng_length", p), eng_length, LEN[p]);
            @(negedge clk);
            pulse_done(5'(20 + p));
            check($sformatf("t2 port%0d match_suc", p), match_suc, 4'b0001 << p);
            check($sformatf("t2 port%0d match_sram", p), match_sram, 20 + p);
            repeat (2) @(negedge clk);
            match_enable[p] = 1'b0;
        end

        // Port 1 drops its request while waiting: result discarded.
        match_enable = 4'b0010;
        wait_req("t3");
        check("t3 eng_length", eng_length, 11);
        @(negedge clk);
        match_enable = 4'b0000;
        @(negedge clk);
        match_enable = 4'b0100;
        pulse_done(5'd9);
        check("t3 no match_suc", match_suc, 0);
        check("t3 match_sram unchanged", match_sram, 23);
        check("t3 idle, no eng_req yet", eng_req, 0);
        @(negedge clk);
        check("t3 next grant eng_req", eng_req, 1);
        check("t3 next grant port2 length", eng_length, 12);
        @(negedge clk);
        pulse_done(5'd5);
        check("t3 port2 match_suc", match_suc, 4'b0100);
        match_enable = 4'b0000;
        repeat (2) @(negedge clk);

        // eng_done outside WAIT is ignored (idle, then during the start pulse).
        pulse_done(5'd31);
        check("t4 idle done no match_suc", match_suc, 0);
        check("t4 idle done match_sram", match_sram, 5);
        match_enable = 4'b1000;
        wait_req("t4");
        pulse_done(5'd30);
        check("t4 issue-cycle done ignored", match_suc, 0);
        @(negedge clk);
        check("t4 still waiting", match_suc, 0);
        pulse_done(5'd12);
        check("t4 match_suc", match_suc, 4'b1000);
        check("t4 match_sram", match_sram, 12);
        match_enable = 4'b0000;
        repeat (2) @(negedge clk);

        // Reset in the middle of WAIT.
        match_enable = 4'b0001;
        wait_req("t5");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5 async eng_dest_port", eng_dest_port, 0);
        check("t5 async eng_length", eng_length, 0);
        check("t5 async match_sram", match_sram, 0);
        check("t5 async eng_req", eng_req, 0);
        check("t5 async eng_abort", eng_abort, 0);
        @(negedge clk);
        match_enable = 4'b0100;
        rst_n = 1'b1;
        wait_req("t5 after reset");
        check("t5 grant port2 length", eng_length, 12);
        check("t5 grant port2 dest", eng_dest_port, 3);
        @(negedge clk);
        pulse_done(5'd3);
        check("t5 port2 match_suc", match_suc, 4'b0100);
        match_enable = 4'b0000;
        repeat (2) @(negedge clk);

`ifdef MATCH_TIMEOUT_EN
        // No result: abort 8 cycles after WAIT entry, next pending port served.
        match_enable = 4'b1001;
        wait_req("t6");
        check("t6 port3 length", eng_length, 13);
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            check($sformatf("t6 no abort wait%0d", i), eng_abort, 0);
        end
        @(negedge clk);
        check("t6 eng_abort", eng_abort, 1);
        check("t6 no match_suc", match_suc, 0);
        @(negedge clk);
        check("t6 abort one cycle", eng_abort, 0);
        check("t6 next grant eng_req", eng_req, 1);
        check("t6 next grant port0 length", eng_length, 40);
        match_enable = 4'b0001;

        // Result on the timeout cycle wins.
        repeat (TO) @(negedge clk);
        pulse_done(5'd7);
        check("t7 match_suc", match_suc, 4'b0001);
        check("t7 match_sram", match_sram, 7);
        check("t7 no abort", eng_abort, 0);
        match_enable = 4'b0000;
        repeat (2) @(negedge clk);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
